n1_mem_arbiter: RTL and testbench
=================================

Name: n1_mem_arbiter

Overview:
- Single-port arbiter and mode sequencer for the n1 core's shared 16-bit program/data RAM.
- Shares the one RAM port between three requesters:
  - host loader: external program load and readback
  - core instruction fetch
  - core data port: store / print
- Sequences the RUN/LOAD mode switch and drains any in-flight read before changing owner, so no requester ever receives another requester's read data.

Parameters:
- ADDR_BITS, 7, RAM address width (128 words).
- DATA_BITS, 16, RAM word width.

Ports:
- clk  input  1  clock; all state on rising edge
- rst  input  1  synchronous, active-high reset
- host_lock  input  1  request LOAD mode; core ports locked out while in LOAD
- host_req  input  1  host access request
- host_we  input  1  host write (1) / read (0)
- host_addr  input  ADDR_BITS  host address
- host_wdata  input  DATA_BITS  host write data
- host_gnt  output  1  host access accepted this cycle
- host_rvalid  output  1  host read data valid
- host_rdata  output  DATA_BITS  host read data
- fetch_req  input  1  instruction fetch request (read only)
- fetch_addr  input  ADDR_BITS  fetch address (pc)
- fetch_gnt  output  1  fetch accepted this cycle
- fetch_rvalid  output  1  fetch data valid
- fetch_rdata  output  DATA_BITS  instruction word
- dat_req  input  1  core data request
- dat_we  input  1  data write (1) / read (0)
- dat_addr  input  ADDR_BITS  data address
- dat_wdata  input  DATA_BITS  data write word
- dat_gnt  output  1  data access accepted this cycle
- dat_rvalid  output  1  data read valid
- dat_rdata  output  DATA_BITS  data read word
- mem_en  output  1  RAM access strobe
- mem_we  output  1  RAM write
- mem_addr  output  ADDR_BITS  RAM address
- mem_wdata  output  DATA_BITS  RAM write data
- mem_rdata  input  DATA_BITS  RAM read data, valid one cycle after mem_en & !mem_we
- mode_load  output  1  1 when state is LOAD

Behaviour:
- One clock domain (clk). Reset is synchronous, active-high, on rst.

Reset:
- state=RUN; all *_rvalid=0; all *_rdata=0; pending-read tag cleared.
- All *_gnt=0, mem_en=0, mem_we=0, mode_load=0 while rst=1.

States: RUN, DRAIN_L, LOAD, DRAIN_R.
- RUN -> DRAIN_L when host_lock=1.
- DRAIN_L -> LOAD after exactly 1 cycle.
- LOAD -> DRAIN_R when host_lock=0.
- DRAIN_R -> RUN after exactly 1 cycle.
- No grants in DRAIN_L or DRAIN_R. A read granted in the cycle before a drain state completes its rvalid during the drain cycle.

Grant rules (combinational from current req and state; at most one gnt per cycle):
- RUN: priority dat > fetch > host.
- LOAD: host only; fetch_req and dat_req are ignored and never granted.
- A request is accepted in the cycle it is granted. Non-granted requesters hold req, addr and data until granted.
- mem_en = OR of gnts. mem_we/mem_addr/mem_wdata are muxed from the winner; fetch winner forces mem_we=0.

Read response:
- A granted read sets a registered owner tag.
- Next cycle: that owner's rvalid=1 and rdata is loaded from mem_rdata. rdata is held until the owner's next read response.
- Writes produce no rvalid.
- Read latency is exactly 1 cycle after gnt. Back-to-back reads give 1 result per cycle.

Boundary conditions:
- host_lock asserted in the same cycle as a core grant: the grant still completes and the transition occurs at the clock edge.
- host_lock toggled during DRAIN_L: the state still completes to LOAD, then re-evaluates.
- Address wrap is the RAM's responsibility. The arbiter passes addresses unmodified; no range check.
- rst mid-read: the pending tag is cleared and no rvalid appears in the cycle after reset.
- Simultaneous dat write and fetch in RUN: dat wins; fetch stalls one cycle.

Optional Feature:
- N1_ARB_RR_EN defined: in RUN, dat and fetch use round-robin.
  - A 1-bit last-winner flop gives priority to the requester not granted last. It is updated only when both request in the same cycle.
  - Host stays lowest. The flop resets to favour dat.
- Undefined: fixed dat > fetch > host; no extra flop.

Test Plan:
- Reset hold: rst=1 with all req=1 for 3 cycles -> every gnt=0, mem_en=0, rvalid=0, mode_load=0; in the first cycle after rst=0 only dat_gnt=1.
- Load/readback:
  - host_lock=1 -> mode_load=1 two edges later.
  - Host writes 0x1203 to addr 0, then reads addr 0 -> host_rvalid=1 one cycle after gnt with host_rdata=0x1203.
  - fetch_req is never granted while mode_load=1.
- Priority: RUN, dat_req(read addr 5) and fetch_req(addr 0) held together -> cycle0 dat_gnt, cycle1 fetch_gnt. Without RR, continuous dat_req starves fetch. With N1_ARB_RR_EN, grants alternate dat, fetch, dat, fetch.
- Drain: fetch read granted, host_lock=1 in the same cycle -> fetch_rvalid=1 next cycle (DRAIN_L) with the correct word; host_gnt first asserts in LOAD.
- Reset mid-read: dat read granted, rst=1 on the next edge -> dat_rvalid stays 0 and state=RUN.
- Back-to-back fetch: addrs 0,1,2 with RAM preloaded 0x1001,0x1002,0x3450 -> fetch_rvalid high 3 consecutive cycles with those words in order.

Source files
------------

// File: rtl/n1_mem_arbiter.sv
// Single-port RAM arbiter and RUN/LOAD mode sequencer for the n1 core.
// Optional macro N1_ARB_RR_EN: round-robin between dat and fetch in RUN.
module n1_mem_arbiter #(
    parameter int ADDR_BITS = 7,
    parameter int DATA_BITS = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 host_lock,
    input  logic                 host_req,
    input  logic                 host_we,
    input  logic [ADDR_BITS-1:0] host_addr,
    input  logic [DATA_BITS-1:0] host_wdata,
    output logic                 host_gnt,
    output logic                 host_rvalid,
    output logic [DATA_BITS-1:0] host_rdata,
    input  logic                 fetch_req,
    input  logic [ADDR_BITS-1:0] fetch_addr,
    output logic                 fetch_gnt,
    output logic                 fetch_rvalid,
    output logic [DATA_BITS-1:0] fetch_rdata,
    input  logic                 dat_req,
    input  logic                 dat_we,
    input  logic [ADDR_BITS-1:0] dat_addr,
    input  logic [DATA_BITS-1:0] dat_wdata,
    output logic                 dat_gnt,
    output logic                 dat_rvalid,
    output logic [DATA_BITS-1:0] dat_rdata,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [DATA_BITS-1:0] mem_wdata,
    input  logic [DATA_BITS-1:0] mem_rdata,
    output logic                 mode_load
);

    localparam int NREQ  = 3;
    localparam int HOST  = 0;
    localparam int FETCH = 1;
    localparam int DAT   = 2;

    typedef enum logic [1:0] {RUN, DRAIN_L, LOAD, DRAIN_R} state_t;

    state_t               state_reg;
    logic [NREQ-1:0]      gnt;
    logic [NREQ-1:0]      rd_vec;
    logic [NREQ-1:0]      pend_reg;
    logic [NREQ-1:0]      rvalid_vec;
    logic [DATA_BITS-1:0] hold_reg  [NREQ];
    logic [DATA_BITS-1:0] rdata_vec [NREQ];
    logic                 dat_first;

`ifdef N1_ARB_RR_EN
    logic prefer_dat_reg;

    // Only a genuine dat/fetch contention moves the round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            prefer_dat_reg <= 1'b1;
        end else if (state_reg == RUN && dat_req && fetch_req) begin
            prefer_dat_reg <= gnt[FETCH];
        end
    end

    assign dat_first = !fetch_req || prefer_dat_reg;
`else
    assign dat_first = 1'b1;
`endif

    always_comb begin
        gnt = '0;
        if (!rst) begin
            if (state_reg == RUN) begin
                if (dat_req && dat_first) begin
                    gnt[DAT] = 1'b1;
                end else if (fetch_req) begin
                    gnt[FETCH] = 1'b1;
                end else if (host_req) begin
                    gnt[HOST] = 1'b1;
                end
            end else if (state_reg == LOAD) begin
                gnt[HOST] = host_req;
            end
        end
    end

    assign rd_vec = {gnt[DAT] & ~dat_we, gnt[FETCH], gnt[HOST] & ~host_we};

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (gnt[DAT]) begin
            mem_we    = dat_we;
            mem_addr  = dat_addr;
            mem_wdata = dat_wdata;
        end else if (gnt[FETCH]) begin
            mem_addr  = fetch_addr;
        end else if (gnt[HOST]) begin
            mem_we    = host_we;
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
        end
    end

    assign mem_en = |gnt;

    // Drain states issue no grants, so the one-hot pending tag empties itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= RUN;
            pend_reg  <= '0;
        end else begin
            pend_reg <= rd_vec;
            case (state_reg)
                RUN:     if (host_lock) state_reg <= DRAIN_L;
                DRAIN_L: state_reg <= LOAD;
                LOAD:    if (!host_lock) state_reg <= DRAIN_R;
                default: state_reg <= RUN;
            endcase
        end
    end

    // RAM data passes straight through on the response cycle and is held after.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_resp
            assign rvalid_vec[gi] = pend_reg[gi] & ~rst;
            assign rdata_vec[gi]  = rvalid_vec[gi] ? mem_rdata : hold_reg[gi];

            always_ff @(posedge clk) begin
                if (rst) begin
                    hold_reg[gi] <= '0;
                end else if (pend_reg[gi]) begin
                    hold_reg[gi] <= mem_rdata;
                end
            end
        end
    endgenerate

    assign host_gnt     = gnt[HOST];
    assign fetch_gnt    = gnt[FETCH];
    assign dat_gnt      = gnt[DAT];
    assign host_rvalid  = rvalid_vec[HOST];
    assign fetch_rvalid = rvalid_vec[FETCH];
    assign dat_rvalid   = rvalid_vec[DAT];
    assign host_rdata   = rdata_vec[HOST];
    assign fetch_rdata  = rdata_vec[FETCH];
    assign dat_rdata    = rdata_vec[DAT];
    assign mode_load    = !rst && (state_reg == LOAD);

endmodule

// File: tb/tb_n1_mem_arbiter.sv
// Self-checking bench for n1_mem_arbiter: directed steps plus a randomized phase
// against a transaction-level model (shadow RAM, mode, pending read).
module tb_n1_mem_arbiter;

    localparam int AW = 7;
    localparam int DW = 16;
`ifdef N1_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          host_lock, host_req, host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_gnt, host_rvalid;
    logic [DW-1:0] host_rdata;
    logic          fetch_req;
    logic [AW-1:0] fetch_addr;
    logic          fetch_gnt, fetch_rvalid;
    logic [DW-1:0] fetch_rdata;
    logic          dat_req, dat_we;
    logic [AW-1:0] dat_addr;
    logic [DW-1:0] dat_wdata;
    logic          dat_gnt, dat_rvalid;
    logic [DW-1:0] dat_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] ram_q;
    logic          mode_load;

    always #5 clk = ~clk;

    n1_mem_arbiter #(.ADDR_BITS(AW), .DATA_BITS(DW)) dut (
        .clk(clk), .rst(rst),
        .host_lock(host_lock), .host_req(host_req), .host_we(host_we),
        .host_addr(host_addr), .host_wdata(host_wdata), .host_gnt(host_gnt),
        .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
        .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata),
        .dat_req(dat_req), .dat_we(dat_we), .dat_addr(dat_addr),
        .dat_wdata(dat_wdata), .dat_gnt(dat_gnt), .dat_rvalid(dat_rvalid),
        .dat_rdata(dat_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(ram_q), .mode_load(mode_load)
    );

    // Single-port RAM with registered read
    logic [DW-1:0] ram [128];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        ram_q <= ram[mem_addr];
        end
    end

    // Reference model state: 0 RUN, 1 DRAIN_L, 2 LOAD, 3 DRAIN_R
    int            n_assert = 0;
    int            n_fail   = 0;
    int            mode     = 0;
    int            pend_who = -1;
    logic [DW-1:0] pend_val;
    logic [DW-1:0] held [3];
    logic [DW-1:0] sh   [128];
    bit            pref_dat = 1'b1;
    bit            g_host, g_fetch, g_dat;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int winner();
        if (rst) return -1;
        if (mode == 0) begin
            if (dat_req && (!RR || !fetch_req || pref_dat)) return 2;
            if (fetch_req) return 1;
            if (host_req) return 0;
            return -1;
        end
        if (mode == 2) return host_req ? 0 : -1;
        return -1;
    endfunction

    task automatic step();
        int w;
        logic [DW-1:0] obs_rd [3];
        logic          obs_rv [3];
        @(negedge clk);
        w = winner();
        obs_rd[0] = host_rdata;  obs_rd[1] = fetch_rdata;  obs_rd[2] = dat_rdata;
        obs_rv[0] = host_rvalid; obs_rv[1] = fetch_rvalid; obs_rv[2] = dat_rvalid;
        chk("host_gnt",  32'(host_gnt),  32'(w == 0));
        chk("fetch_gnt", 32'(fetch_gnt), 32'(w == 1));
        chk("dat_gnt",   32'(dat_gnt),   32'(w == 2));
        chk("mem_en",    32'(mem_en),    32'(w >= 0));
        chk("mode_load", 32'(mode_load), 32'(!rst && mode == 2));
        if (w == 0) begin
            chk("mem_we_h", 32'(mem_we), 32'(host_we));
            chk("mem_addr_h", 32'(mem_addr), 32'(host_addr));
            if (host_we) chk("mem_wdata_h", 32'(mem_wdata), 32'(host_wdata));
        end else if (w == 1) begin
            chk("mem_we_f", 32'(mem_we), 32'd0);
            chk("mem_addr_f", 32'(mem_addr), 32'(fetch_addr));
        end else if (w == 2) begin
            chk("mem_we_d", 32'(mem_we), 32'(dat_we));
            chk("mem_addr_d", 32'(mem_addr), 32'(dat_addr));
            if (dat_we) chk("mem_wdata_d", 32'(mem_wdata), 32'(dat_wdata));
        end
        for (int o = 0; o < 3; o++) begin
            chk($sformatf("rvalid%0d", o), 32'(obs_rv[o]), 32'(!rst && pend_who == o));
            if (!rst)
                chk($sformatf("rdata%0d", o), 32'(obs_rd[o]),
                    32'((pend_who == o) ? pend_val : held[o]));
        end
        g_host  = (w == 0);
        g_fetch = (w == 1);
        g_dat   = (w == 2);
        @(posedge clk);
        if (rst) begin
            mode = 0; pend_who = -1; pref_dat = 1'b1;
            for (int o = 0; o < 3; o++) held[o] = '0;
        end else begin
            if (pend_who >= 0) held[pend_who] = pend_val;
            pend_who = -1;
            if (w == 0) begin
                if (host_we) sh[host_addr] = host_wdata;
                else begin pend_who = 0; pend_val = sh[host_addr]; end
            end else if (w == 1) begin
                pend_who = 1; pend_val = sh[fetch_addr];
            end else if (w == 2) begin
                if (dat_we) sh[dat_addr] = dat_wdata;
                else begin pend_who = 2; pend_val = sh[dat_addr]; end
            end
            if (mode == 0 && dat_req && fetch_req) pref_dat = (w == 1);
            case (mode)
                0: if (host_lock) mode = 1;
                1: mode = 2;
                2: if (!host_lock) mode = 3;
                default: mode = 0;
            endcase
        end
        #1;
    endtask

    initial begin
        rst = 1'b1; host_lock = 0; host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
        fetch_req = 0; fetch_addr = '0; dat_req = 0; dat_we = 0; dat_addr = '0; dat_wdata = '0;
        #1;
        step(); step();
        rst = 1'b0;

        // Fill the RAM through the host port (host wins in RUN when alone)
        host_req = 1; host_we = 1;
        for (int i = 0; i < 128; i++) begin
            host_addr  = 7'(i);
            host_wdata = (i == 0) ? 16'h1001 : (i == 1) ? 16'h1002 :
                         (i == 2) ? 16'h3450 : 16'($urandom);
            step();
        end
        host_req = 0;
        step();

        // Reset hold with every request raised, then dat > fetch > host
        rst = 1; host_req = 1; host_we = 0; host_addr = 7'd3;
        fetch_req = 1; fetch_addr = 7'd0; dat_req = 1; dat_we = 0; dat_addr = 7'd5;
        repeat (3) step();
        rst = 0;
        step();
        chk("first_after_rst_dat", 32'(g_dat), 32'd1);
        dat_req = 0; step();
        fetch_req = 0; step();
        host_req = 0; step();
        step();

        // Contention: fixed priority starves fetch, round-robin alternates
        dat_req = 1; dat_addr = 7'd5; fetch_req = 1; fetch_addr = 7'd0;
        repeat (4) step();
        dat_req = 0; fetch_req = 0; step();

        // Back-to-back fetch 0,1,2
        fetch_req = 1;
        for (int a = 0; a < 3; a++) begin fetch_addr = 7'(a); step(); end
        fetch_req = 0; step(); step();

        // Dat write and fetch together: dat wins, fetch waits
        dat_req = 1; dat_we = 1; dat_addr = 7'd9; dat_wdata = 16'hbeef;
        fetch_req = 1; fetch_addr = 7'd9;
        step(); dat_req = 0; dat_we = 0; step(); fetch_req = 0; step();

        // Fetch granted in the same cycle as host_lock drains in DRAIN_L
        fetch_req = 1; fetch_addr = 7'd1; host_lock = 1;
        step();
        fetch_req = 0; host_req = 1; host_we = 1; host_addr = 7'd0; host_wdata = 16'h1203;
        step();
        fetch_req = 1; dat_req = 1;
        step();
        chk("host_write_in_load", 32'(g_host), 32'd1);
        host_we = 0;
        step();
        host_req = 0;
        repeat (2) step();
        chk("fetch_locked_out", 32'(fetch_gnt), 32'd0);

        // Leave LOAD: DRAIN_R then RUN
        host_lock = 0;
        repeat (3) step();
        dat_req = 0; fetch_req = 0; step();

        // host_lock pulsed during DRAIN_L still completes to LOAD
        host_lock = 1; step(); host_lock = 0; repeat (4) step();

        // Reset while a dat read is outstanding
        dat_req = 1; dat_we = 0; dat_addr = 7'd7; step();
        dat_req = 0; rst = 1; step();
        rst = 0; step(); step();

        // Randomized traffic with hold-until-granted requesters
        for (int c = 0; c < 600; c++) begin
            if (!dat_req || g_dat) begin
                dat_req = 1'($urandom_range(0, 1)); dat_we = 1'($urandom_range(0, 1));
                dat_addr = 7'($urandom); dat_wdata = 16'($urandom);
            end
            if (!fetch_req || g_fetch) begin
                fetch_req = 1'($urandom_range(0, 1)); fetch_addr = 7'($urandom);
            end
            if (!host_req || g_host) begin
                host_req = 1'($urandom_range(0, 1)); host_we = 1'($urandom_range(0, 1));
                host_addr = 7'($urandom); host_wdata = 16'($urandom);
            end
            if ($urandom_range(0, 19) == 0) host_lock = ~host_lock;
            rst = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
